// File: rtl/stream_mux_rr_pkg.sv
// Shared constants for the round-robin stream multiplexer: select-mode encoding
// and the two output-register states.
package stream_mux_rr_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;
endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so the channel after
// last_grant sits at bit 0, pick the lowest set bit, rotate the index back.
module stream_mux_rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last_grant,
  output logic [SEL_W-1:0] grant,
  output logic             grant_valid
);
  int                start;
  logic [2*N_CH-1:0] req_dbl;
  logic [N_CH-1:0]   rot;

  always_comb begin
    start       = (int'(last_grant) + 1) % N_CH;
    req_dbl     = {req, req} >> start;
    rot         = req_dbl[N_CH-1:0];
    grant_valid = |rot;
    grant       = '0;
    // descending scan so the lowest rotated index (highest priority) wins
    for (int k = N_CH-1; k >= 0; k--)
      if (rot[k]) grant = SEL_W'((start + k) % N_CH);
  end
endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with manual or round-robin selection and a
// single registered output stage (1-cycle latency, full throughput).
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  rr_en,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
);
  logic [0:0]       state;
  logic [SEL_W-1:0] last_grant, rr_grant, man_grant, grant;
  logic             rr_gv, man_gv, grant_valid, load, accept;
  logic [WIDTH-1:0] grant_data;

  stream_mux_rr_arbiter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_arb (
    .req        (in_valid),
    .last_grant (last_grant),
    .grant      (rr_grant),
    .grant_valid(rr_gv)
  );

  // out-of-range sel never matches a channel, so it yields no grant
  always_comb begin
    man_gv    = 1'b0;
    man_grant = sel;
    for (int i = 0; i < N_CH; i++)
      if (sel == SEL_W'(i) && in_valid[i]) man_gv = 1'b1;
  end

  assign grant       = (rr_en == MODE_RR) ? rr_grant : man_grant;
  assign grant_valid = (rr_en == MODE_RR) ? rr_gv    : man_gv;
  assign load        = (state == ST_EMPTY) || out_ready;
  assign accept      = !rst && load && grant_valid;
  assign out_valid   = (state == ST_FULL);

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = accept && (grant == SEL_W'(i));
      if (grant == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      out_data   <= '0;
      out_ch     <= '0;
      last_grant <= SEL_W'(N_CH-1);
    end else if (load) begin
      if (grant_valid) begin
        state      <= ST_FULL;
        out_data   <= grant_data;
        out_ch     <= grant;
        last_grant <= grant;
      end else begin
        state <= ST_EMPTY;
      end
    end
  end
endmodule
